serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
Multi-cycle, digit-serial integer add/subtract unit for the datapath ALU. It generalises the 32-bit ripple-borrow subtractor to a parametrised width and adds an add/subtract mode select and a digit-per-cycle processing rate. It also provides a start/done handshake and carry/borrow, signed-overflow and zero flags. The ALU control FSM issues operations through it when area matters more than single-cycle latency.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 2.
DIGIT, 4, bits processed per clock; WIDTH % DIGIT must be 0, otherwise elaboration fails. N = WIDTH/DIGIT is the number of processing cycles.

Ports:
clk  in  1  single clock, all state updates on rising edge.
rst_n  in  1  reset, synchronous, active-low.
start  in  1  request; accepted only on an edge where ready=1.
sub  in  1  mode, sampled with start: 1 = A-B, 0 = A+B.
a  in  WIDTH  operand A, sampled with start.
b  in  WIDTH  operand B, sampled with start.
ready  out  1  high in IDLE and DONE states; new start may be accepted.
done  out  1  one-cycle pulse: result and flags updated this cycle.
result  out  WIDTH  final sum/difference, registered.
cout  out  1  add: carry out of MSB; sub: borrow out (1 iff A<B unsigned).
overflow  out  1  two's-complement signed overflow.
zero  out  1  result == 0.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, digit counter=0, internal operand/partial registers=0.
  - result=0, cout=0, overflow=0, zero=0, done=0.
  - ready=1 after that edge.
  - Reset mid-operation aborts the operation: no done pulse, and no partial value ever reaches result.
- States IDLE, RUN, DONE:
  - IDLE: ready=1. On start=1, latch a, b and sub; clear the chain bit; counter=0; go to RUN.
  - RUN: ready=0. Each edge processes digit[counter] (bits counter*DIGIT .. counter*DIGIT+DIGIT-1).
    - Per bit, sub: d = a^b^bw; bw' = (~a&b) | (bw & ~(a^b)).
    - Per bit, add: s = a^b^c; c' = (a&b) | (c&(a^b)).
    - Chain bit carried between cycles in a register; initial chain = 0 in both modes.
    - On the edge processing digit N-1: load result, cout and flags; go to DONE.
  - DONE: done=1 and ready=1 for exactly one cycle.
    - start=1 on that edge: accepted, go to RUN (back-to-back, no idle bubble).
    - Otherwise go to IDLE.
- Latency: start sampled at edge E means done=1 in the cycle following edge E+N. Throughput is one op per N+1 cycles.
- result and flags hold their last values until the next DONE load. They do not change during RUN.
- Flags, with sa/sb/sr as the MSBs of the latched operands and the result:
  - Add overflow: (sa==sb) && (sr!=sa).
  - Sub overflow: (sa!=sb) && (sr!=sa).
  - zero is computed on the full WIDTH result.
- Sequencing rules:
  - start while in RUN is ignored.
  - a, b and sub changes after acceptance have no effect.
  - done never asserts without a prior accepted start.
- DIGIT=WIDTH (N=1): single RUN cycle, then DONE.
- DIGIT=1: bit-serial, N=WIDTH.
- Counter width is clog2(N), minimum 1. Counter does not wrap mid-operation; it resets to 0 on each accept.

Test Plan:
1. WIDTH=32, DIGIT=4, sub=1, a=0x0000000A, b=0x00000003 -> result=0x00000007, cout=0, overflow=0, zero=0; done high exactly in the cycle after edge E+8.
2. sub=1, a=0x00000003, b=0x0000000A -> result=0xFFFFFFF9, cout=1 (borrow), overflow=0, zero=0.
3. sub=1, a=0x80000000, b=0x00000001 -> result=0x7FFFFFFF, overflow=1, cout=0. Then sub=0, a=0xFFFFFFFF, b=0x00000001 -> result=0, cout=1, zero=1, overflow=0.
4. Handshake:
   - Pulse start with new operands during RUN -> ignored; result matches the first op.
   - Change a/b mid-RUN -> no effect.
   - Assert start in the DONE cycle with a=5, b=5, sub=1 -> accepted; next done gives result=0, zero=1.
5. Run a=0x12345678, b=0x0000FFFF, sub=1, and drive rst_n=0 on the edge after 3 digits -> next cycle state IDLE, ready=1, result=0, all flags 0, and done never pulses for the aborted op.
6. Parameter sweep (WIDTH,DIGIT) = (32,1), (32,32), (16,8), (8,2) with 1000 random ops each -> results and flags match a reference model, and done latency = N+1 edges after acceptance in every case.

Source files
------------

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial add/subtract with start/done handshake.
// Ports: clk, rst_n (sync, active-low), start, sub, a, b -> ready, done,
//   result, cout (carry/borrow), overflow (signed), zero.
module serial_addsub #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] acc;
   logic             mode;
   logic             chain;

   logic [DIGIT-1:0] dig;
   logic [DIGIT:0]   ch;
   logic [WIDTH-1:0] acc_nxt;
   logic             last;
   logic             accept;
   logic             sa;
   logic             sb;
   logic             sr;
   logic             ovf_nxt;

   assign accept = start & ready;
   assign last   = (cnt == CW'(N - 1));

   // Operands shift right each cycle, so the active digit is always
   // the low DIGIT bits; no variable part-select is needed.
   always_comb begin
      ch    = '0;
      dig   = '0;
      ch[0] = chain;
      for (int i = 0; i < DIGIT; i++) begin
         dig[i] = opa[i] ^ opb[i] ^ ch[i];
         if (mode)
            ch[i+1] = (~opa[i] & opb[i]) | (ch[i] & ~(opa[i] ^ opb[i]));
         else
            ch[i+1] = (opa[i] & opb[i]) | (ch[i] & (opa[i] ^ opb[i]));
      end
   end

   // New digit enters at the top; after N cycles acc holds the full word.
   assign acc_nxt = WIDTH'({dig, acc} >> DIGIT);

   // On the final digit the low digit of the shifted operands holds
   // the original MSBs.
   assign sa = opa[DIGIT-1];
   assign sb = opb[DIGIT-1];
   assign sr = dig[DIGIT-1];
   assign ovf_nxt = mode ? ((sa != sb) && (sr != sa))
                         : ((sa == sb) && (sr != sa));

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      done      = 1'b0;
      unique case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (last) state_nxt = S_DONE;
         end
         S_DONE: begin
            ready     = 1'b1;
            done      = 1'b1;
            state_nxt = start ? S_RUN : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         opa      <= '0;
         opb      <= '0;
         acc      <= '0;
         mode     <= 1'b0;
         chain    <= 1'b0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else if (accept) begin
         cnt   <= '0;
         opa   <= a;
         opb   <= b;
         acc   <= '0;
         mode  <= sub;
         chain <= 1'b0;
      end else if (state == S_RUN) begin
         opa   <= opa >> DIGIT;
         opb   <= opb >> DIGIT;
         acc   <= acc_nxt;
         chain <= ch[DIGIT];
         if (!last) cnt <= cnt + 1'b1;
         if (last) begin
            result   <= acc_nxt;
            cout     <= ch[DIGIT];
            overflow <= ovf_nxt;
            zero     <= (acc_nxt == '0);
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and randomised checks of serial_addsub
// across several WIDTH/DIGIT configurations.
module tb_serial_addsub;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  start_v;
   logic        sub_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   wire  [4:0]  ready_v;
   wire  [4:0]  done_v;
   wire  [4:0]  cout_v;
   wire  [4:0]  ovf_v;
   wire  [4:0]  zero_v;
   wire  [31:0] r0;
   wire  [31:0] r1;
   wire  [31:0] r2;
   wire  [15:0] r3;
   wire  [7:0]  r4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(32), .DIGIT(4)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_i),
      .a(a_i), .b(b_i), .ready(ready_v[0]), .done(done_v[0]),
      .result(r0), .cout(cout_v[0]), .overflow(ovf_v[0]), .zero(zero_v[0])
   );
   serial_addsub #(.WIDTH(32), .DIGIT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_i),
      .a(a_i), .b(b_i), .ready(ready_v[1]), .done(done_v[1]),
      .result(r1), .cout(cout_v[1]), .overflow(ovf_v[1]), .zero(zero_v[1])
   );
   serial_addsub #(.WIDTH(32), .DIGIT(32)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub_i),
      .a(a_i), .b(b_i), .ready(ready_v[2]), .done(done_v[2]),
      .result(r2), .cout(cout_v[2]), .overflow(ovf_v[2]), .zero(zero_v[2])
   );
   serial_addsub #(.WIDTH(16), .DIGIT(8)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .sub(sub_i),
      .a(a_i[15:0]), .b(b_i[15:0]), .ready(ready_v[3]), .done(done_v[3]),
      .result(r3), .cout(cout_v[3]), .overflow(ovf_v[3]), .zero(zero_v[3])
   );
   serial_addsub #(.WIDTH(8), .DIGIT(2)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start_v[4]), .sub(sub_i),
      .a(a_i[7:0]), .b(b_i[7:0]), .ready(ready_v[4]), .done(done_v[4]),
      .result(r4), .cout(cout_v[4]), .overflow(ovf_v[4]), .zero(zero_v[4])
   );

   function automatic int wid(input int k);
      case (k)
         3:       return 16;
         4:       return 8;
         default: return 32;
      endcase
   endfunction

   function automatic int ncyc(input int k);
      case (k)
         0:       return 8;
         1:       return 32;
         2:       return 1;
         3:       return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] getres(input int k);
      case (k)
         0:       return r0;
         1:       return r1;
         2:       return r2;
         3:       return {16'h0, r3};
         default: return {24'h0, r4};
      endcase
   endfunction

   function automatic logic [31:0] getflg(input int k);
      return {29'h0, cout_v[k], ovf_v[k], zero_v[k]};
   endfunction

   task automatic model(input int w, input logic s,
                        input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic [31:0] f);
      logic [31:0] mask;
      logic [31:0] xm;
      logic [31:0] ym;
      logic [32:0] full;
      logic        c;
      logic        o;
      logic        sa;
      logic        sb;
      logic        sr;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      xm   = x & mask;
      ym   = y & mask;
      if (s) begin
         r = (xm - ym) & mask;
         c = (xm < ym);
      end else begin
         full = {1'b0, xm} + {1'b0, ym};
         r    = full[31:0] & mask;
         c    = full[w];
      end
      sa = xm[w-1];
      sb = ym[w-1];
      sr = r[w-1];
      o  = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
      f  = {29'h0, c, o, (r == 32'h0)};
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives a request before the next rising edge; returns #1 after it.
   task automatic start_op(input int k, input logic s,
                           input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      a_i        = x;
      b_i        = y;
      sub_i      = s;
      start_v    = '0;
      start_v[k] = 1'b1;
      @(posedge clk);
      #1;
      start_v = '0;
   endtask

   // Counts edges since acceptance until done is seen, bounded.
   task automatic wait_done(input int k, input int init, output int cyc);
      cyc = init;
      while (done_v[k] !== 1'b1 && cyc < 80) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic dir_op(input string tag, input logic s,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic [31:0] ef);
      int cyc;
      start_op(0, s, x, y);
      wait_done(0, 1, cyc);
      chk({tag, "_lat"}, cyc, 9);
      chk({tag, "_res"}, r0, er);
      chk({tag, "_flg"}, getflg(0), ef);
      chk({tag, "_rdy"}, {31'h0, ready_v[0]}, 1);
   endtask

   initial begin
      int          cyc;
      int          seen;
      logic        s;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] er;
      logic [31:0] ef;

      rst_n   = 1'b0;
      start_v = '0;
      sub_i   = 1'b0;
      a_i     = '0;
      b_i     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {27'h0, ready_v}, 32'h1F);
      chk("rst_done", {27'h0, done_v}, 0);
      chk("rst_res", r0, 0);
      chk("rst_flg", getflg(0), 0);
      @(negedge clk);
      rst_n = 1'b1;

      dir_op("t1", 1'b1, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 0);
      dir_op("t2", 1'b1, 32'h0000_0003, 32'h0000_000A, 32'hFFFF_FFF9, 32'h4);
      dir_op("t3s", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h2);
      dir_op("t3a", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h5);

      // start and operand changes during RUN must be ignored
      start_op(0, 1'b0, 32'h0000_0100, 32'h0000_0001);
      @(posedge clk);
      #1;
      @(negedge clk);
      a_i        = 32'h55;
      b_i        = 32'h22;
      sub_i      = 1'b1;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v = '0;
      a_i     = 32'hFFFF_FFFF;
      wait_done(0, 3, cyc);
      chk("t4_lat", cyc, 9);
      chk("t4_res", r0, 32'h101);
      chk("t4_flg", getflg(0), 0);

      // back-to-back accept in the DONE cycle
      a_i        = 32'd5;
      b_i        = 32'd5;
      sub_i      = 1'b1;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v = '0;
      chk("t4b_run", {30'h0, ready_v[0], done_v[0]}, 0);
      chk("t4b_hold", r0, 32'h101);
      wait_done(0, 1, cyc);
      chk("t4b_lat", cyc, 9);
      chk("t4b_res", r0, 0);
      chk("t4b_flg", getflg(0), 32'h1);

      // reset mid-operation aborts it
      dir_op("t5pre", 1'b0, 32'd1, 32'd2, 32'd3, 0);
      start_op(0, 1'b1, 32'h1234_5678, 32'h0000_FFFF);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_ready", {31'h0, ready_v[0]}, 1);
      chk("t5_done", {31'h0, done_v[0]}, 0);
      chk("t5_res", r0, 0);
      chk("t5_flg", getflg(0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done_v[0] === 1'b1) seen = 1;
      end
      chk("t5_nodone", seen, 0);
      chk("t5_res2", r0, 0);

      // randomised sweep over the other configurations
      for (int k = 1; k <= 4; k++) begin
         for (int i = 0; i < 1000; i++) begin
            s = 1'($urandom_range(0, 1));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 9))
               0: y = x;
               1: x = 32'hFFFF_FFFF;
               2: x = 32'h1 << (wid(k) - 1);
               3: y = 32'h1;
               4: x = 32'h0;
               default: ;
            endcase
            if (i % 3 == 0) @(negedge clk);
            start_op(k, s, x, y);
            wait_done(k, 1, cyc);
            model(wid(k), s, x, y, er, ef);
            chk($sformatf("sw%0d_lat", k), cyc, ncyc(k) + 1);
            chk($sformatf("sw%0d_res", k), getres(k), er);
            chk($sformatf("sw%0d_flg", k), getflg(k), ef);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
